// File: rtl/beta_pkg.sv
// -----------------------------------------------------------------------------
// beta_pkg
// Shared types and constants for the beta decode/exe hazard scheduler.
//   hazard_state_t : scheduler FSM states (idle / waiting on a blocked instr)
//   hazard_req_t   : the fields of a decoded instruction the scheduler needs,
//                    held while the instruction waits for its operands
//   HZ_DEPTH_DEFAULT : default number of in-flight register writers tracked
//   HZ_ADDR_W        : register address width (RV32I)
// -----------------------------------------------------------------------------
package beta_pkg;

   localparam int HZ_DEPTH_DEFAULT = 2;
   localparam int HZ_ADDR_W        = 5;

   typedef enum logic [0:0] {
      HZ_IDLE,
      HZ_WAIT
   } hazard_state_t;

   typedef struct packed {
      logic [HZ_ADDR_W-1:0] rs1;
      logic [HZ_ADDR_W-1:0] rs2;
      logic                 rs1_used;
      logic                 rs2_used;
      logic [HZ_ADDR_W-1:0] rd;
      logic                 rd_wr;
   } hazard_req_t;

endpackage

// File: rtl/beta_hazard_sb.sv
// -----------------------------------------------------------------------------
// beta_hazard_sb
// In-order scoreboard FIFO of destination registers still in flight.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   flush_i              empty the FIFO (wins over push/pop)
//   push_i, push_rd_i    append a destination register at the tail
//   pop_i                retire the head (ignored when empty)
//   src1_i, src2_i       source addresses to compare against valid entries
//   hit*_o               source matches at least one valid entry
//   head_only*_o         the head is the one and only matching entry
//   head_rd_o            destination register at the head
//   empty_o, full_o      occupancy flags
//   count_o              occupancy, 0..Depth
// -----------------------------------------------------------------------------
module beta_hazard_sb
   import beta_pkg::*;
#(
   parameter int Depth     = HZ_DEPTH_DEFAULT,
   parameter int AddrWidth = HZ_ADDR_W
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic [AddrWidth-1:0]   push_rd_i,
   input  logic                   pop_i,
   input  logic [AddrWidth-1:0]   src1_i,
   input  logic [AddrWidth-1:0]   src2_i,
   output logic                   hit1_o,
   output logic                   hit2_o,
   output logic                   head_only1_o,
   output logic                   head_only2_o,
   output logic [AddrWidth-1:0]   head_rd_o,
   output logic                   empty_o,
   output logic                   full_o,
   output logic [$clog2(Depth):0] count_o
);

   localparam int PtrW = $clog2(Depth);
   localparam int CntW = PtrW + 1;

   logic [AddrWidth-1:0] rd_q [Depth];
   logic [AddrWidth-1:0] rd_d [Depth];
   logic [PtrW-1:0]      head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0]      count_q, count_d;
   logic [Depth-1:0]     valid, match1, match2, head_oh;
   logic                 do_push, do_pop;

   // An entry is valid when its distance from the head (mod Depth) is below
   // the occupancy; Depth is a power of two so the subtraction wraps freely.
   for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
      logic [PtrW-1:0] offset;
      assign offset      = PtrW'(gi) - head_q;
      assign valid[gi]   = {1'b0, offset} < count_q;
      assign match1[gi]  = valid[gi] & (rd_q[gi] == src1_i);
      assign match2[gi]  = valid[gi] & (rd_q[gi] == src2_i);
      assign head_oh[gi] = (head_q == PtrW'(gi));
   end

   assign hit1_o       = |match1;
   assign hit2_o       = |match2;
   assign head_only1_o = hit1_o & (match1 == head_oh);
   assign head_only2_o = hit2_o & (match2 == head_oh);
   assign head_rd_o    = rd_q[head_q];
   assign empty_o      = (count_q == '0);
   assign full_o       = (count_q == CntW'(Depth));
   assign count_o      = count_q;

   always_comb begin
      rd_d    = rd_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      do_pop  = pop_i & ~empty_o;
      // A push into a full FIFO is legal only when the head leaves this cycle.
      do_push = push_i & (~full_o | do_pop);
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) begin
            rd_d[tail_q] = push_rd_i;
            tail_d       = tail_q + PtrW'(1);
         end
         if (do_pop) begin
            head_d = head_q + PtrW'(1);
         end
         count_d = count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_q    <= '{default: '0};
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         rd_q    <= rd_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/beta_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// beta_hazard_ctrl
// RAW hazard scheduler at the beta decode/exe boundary. Each new decoded
// instruction is issued at once, issued with writeback forwarding, or held
// (stall) until the blocking writer retires.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   dec_*                   new decoded instruction (pulse + fields)
//   wb_valid_i, wb_rd_addr_i  in-order writeback retiring the oldest writer
//   flush_i                 drop all in-flight and waiting state
//   issue_o, stall_o        release to exe / hold fetch+decode
//   forward_en_o, forward_src_o  use wb data for opA ([0]) / opB ([1])
//   inflight_o              scoreboard occupancy
//   proto_err_o             sticky protocol error
// Optional macro BETA_HAZARD_PERF_EN adds stall_cnt_o / fwd_cnt_o saturating
// performance counters (cleared by reset only).
// -----------------------------------------------------------------------------
module beta_hazard_ctrl
   import beta_pkg::*;
#(
   parameter int Depth     = HZ_DEPTH_DEFAULT,
   parameter int AddrWidth = HZ_ADDR_W
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   dec_new_instr_i,
   input  logic [AddrWidth-1:0]   dec_rsrc1_addr_i,
   input  logic [AddrWidth-1:0]   dec_rsrc2_addr_i,
   input  logic                   dec_rs1_used_i,
   input  logic                   dec_rs2_used_i,
   input  logic [AddrWidth-1:0]   dec_rd_addr_i,
   input  logic                   dec_rd_wr_i,
   input  logic                   wb_valid_i,
   input  logic [AddrWidth-1:0]   wb_rd_addr_i,
   input  logic                   flush_i,
   output logic                   issue_o,
   output logic                   stall_o,
   output logic                   forward_en_o,
   output logic [1:0]             forward_src_o,
   output logic [$clog2(Depth):0] inflight_o,
   output logic                   proto_err_o
`ifdef BETA_HAZARD_PERF_EN
   ,
   output logic [31:0]            stall_cnt_o,
   output logic [31:0]            fwd_cnt_o
`endif
);

   hazard_state_t state_q, state_d;
   hazard_req_t   req_q, req_d, cur;
   logic          proto_err_q, proto_err_d;

   logic          hit1, hit2, head_only1, head_only2, sb_empty, sb_full;
   logic [AddrWidth-1:0] head_rd;
   logic          req_pending, live1, live2, push_req, pop;
   logic          fwd1, fwd2, hazard, issue, stall, push, err_now;
   logic [1:0]    fwd_src;

   always_comb begin
      // In WAIT the held instruction is evaluated; decode inputs are ignored.
      if (state_q == HZ_WAIT) begin
         cur = req_q;
      end else begin
         cur = '{rs1: dec_rsrc1_addr_i, rs2: dec_rsrc2_addr_i,
                 rs1_used: dec_rs1_used_i, rs2_used: dec_rs2_used_i,
                 rd: dec_rd_addr_i, rd_wr: dec_rd_wr_i};
      end
   end

   beta_hazard_sb #(
      .Depth     (Depth),
      .AddrWidth (AddrWidth)
   ) u_sb (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush_i      (flush_i),
      .push_i       (push),
      .push_rd_i    (cur.rd),
      .pop_i        (pop),
      .src1_i       (cur.rs1),
      .src2_i       (cur.rs2),
      .hit1_o       (hit1),
      .hit2_o       (hit2),
      .head_only1_o (head_only1),
      .head_only2_o (head_only2),
      .head_rd_o    (head_rd),
      .empty_o      (sb_empty),
      .full_o       (sb_full),
      .count_o      (inflight_o)
   );

   always_comb begin
      req_pending = (state_q == HZ_WAIT) | dec_new_instr_i;
      live1       = cur.rs1_used & (cur.rs1 != '0);
      live2       = cur.rs2_used & (cur.rs2 != '0);
      push_req    = cur.rd_wr & (cur.rd != '0);
      pop         = wb_valid_i & ~sb_empty;
      // Forwarding works only when the retiring head is the sole producer.
      fwd1        = live1 & head_only1 & wb_valid_i;
      fwd2        = live2 & head_only2 & wb_valid_i;
      hazard      = (live1 & hit1 & ~fwd1) | (live2 & hit2 & ~fwd2)
                  | (sb_full & push_req & ~pop);
      issue       = req_pending & ~hazard & ~flush_i;
      if (state_q == HZ_WAIT) begin
         stall = ~issue;
      end else begin
         stall = dec_new_instr_i & hazard & ~flush_i;
      end
      fwd_src     = issue ? {fwd2, fwd1} : 2'b00;
      push        = issue & push_req;
      err_now     = (dec_new_instr_i & (state_q == HZ_WAIT) & stall)
                  | (wb_valid_i & (sb_empty | (wb_rd_addr_i != head_rd)));
      proto_err_d = proto_err_q | err_now;

      state_d = state_q;
      req_d   = req_q;
      if (flush_i) begin
         state_d = HZ_IDLE;
      end else if (state_q == HZ_IDLE) begin
         if (dec_new_instr_i & hazard) begin
            state_d = HZ_WAIT;
            req_d   = cur;
         end
      end else if (issue) begin
         state_d = HZ_IDLE;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= HZ_IDLE;
         req_q       <= '0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign issue_o       = issue;
   assign stall_o       = stall;
   assign forward_src_o = fwd_src;
   assign forward_en_o  = |fwd_src;
   assign proto_err_o   = proto_err_q;

`ifdef BETA_HAZARD_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      fwd_cnt_d   = fwd_cnt_q;
      if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (issue && (|fwd_src) && fwd_cnt_q != 32'hFFFF_FFFF) begin
         fwd_cnt_d = fwd_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_beta_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_beta_hazard_ctrl
// Directed scoreboard bench for beta_hazard_ctrl (Depth=2). Each cycle drives
// one decode/writeback pattern, pushes the expected outputs, then pops and
// compares them against the DUT mid-cycle.
// -----------------------------------------------------------------------------
module tb_beta_hazard_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       dec_new_instr_i = 1'b0;
   logic [4:0] dec_rsrc1_addr_i = '0;
   logic [4:0] dec_rsrc2_addr_i = '0;
   logic       dec_rs1_used_i = 1'b0;
   logic       dec_rs2_used_i = 1'b0;
   logic [4:0] dec_rd_addr_i = '0;
   logic       dec_rd_wr_i = 1'b0;
   logic       wb_valid_i = 1'b0;
   logic [4:0] wb_rd_addr_i = '0;
   logic       flush_i = 1'b0;
   logic       issue_o, stall_o, forward_en_o, proto_err_o;
   logic [1:0] forward_src_o;
   logic [1:0] inflight_o;
`ifdef BETA_HAZARD_PERF_EN
   logic [31:0] stall_cnt_o, fwd_cnt_o;
`endif

   always #5 clk_i = ~clk_i;

   beta_hazard_ctrl u_dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .dec_new_instr_i  (dec_new_instr_i),
      .dec_rsrc1_addr_i (dec_rsrc1_addr_i),
      .dec_rsrc2_addr_i (dec_rsrc2_addr_i),
      .dec_rs1_used_i   (dec_rs1_used_i),
      .dec_rs2_used_i   (dec_rs2_used_i),
      .dec_rd_addr_i    (dec_rd_addr_i),
      .dec_rd_wr_i      (dec_rd_wr_i),
      .wb_valid_i       (wb_valid_i),
      .wb_rd_addr_i     (wb_rd_addr_i),
      .flush_i          (flush_i),
      .issue_o          (issue_o),
      .stall_o          (stall_o),
      .forward_en_o     (forward_en_o),
      .forward_src_o    (forward_src_o),
      .inflight_o       (inflight_o),
      .proto_err_o      (proto_err_o)
`ifdef BETA_HAZARD_PERF_EN
      ,
      .stall_cnt_o      (stall_cnt_o),
      .fwd_cnt_o        (fwd_cnt_o)
`endif
   );

   typedef struct {
      logic       issue;
      logic       stall;
      logic [1:0] fsrc;
      logic [1:0] infl;
      logic       err;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc_n    = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One transaction: drive at the falling edge, compare 2 time units later.
   task automatic cyc(input logic nw, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic wr,
                      input logic wbv, input logic [4:0] wbrd, input logic fl,
                      input logic e_iss, input logic e_stl, input logic [1:0] e_fs,
                      input logic [1:0] e_inf, input logic e_err);
      exp_t e;
      @(negedge clk_i);
      cyc_n++;
      dec_new_instr_i  = nw;
      dec_rsrc1_addr_i = rs1;
      dec_rs1_used_i   = u1;
      dec_rsrc2_addr_i = rs2;
      dec_rs2_used_i   = u2;
      dec_rd_addr_i    = rd;
      dec_rd_wr_i      = wr;
      wb_valid_i       = wbv;
      wb_rd_addr_i     = wbrd;
      flush_i          = fl;
      exp_q.push_back('{issue: e_iss, stall: e_stl, fsrc: e_fs, infl: e_inf, err: e_err});
      #2;
      e = exp_q.pop_front();
      check_val($sformatf("c%0d issue", cyc_n), 32'(issue_o), 32'(e.issue));
      check_val($sformatf("c%0d stall", cyc_n), 32'(stall_o), 32'(e.stall));
      check_val($sformatf("c%0d fwd_src", cyc_n), 32'(forward_src_o), 32'(e.fsrc));
      check_val($sformatf("c%0d fwd_en", cyc_n), 32'(forward_en_o), 32'(|e.fsrc));
      check_val($sformatf("c%0d inflight", cyc_n), 32'(inflight_o), 32'(e.infl));
      check_val($sformatf("c%0d proto_err", cyc_n), 32'(proto_err_o), 32'(e.err));
      $display("c%0d new=%0b rs1=%0d/%0b rs2=%0d/%0b rd=%0d/%0b wb=%0b/%0d fl=%0b -> issue=%0b stall=%0b fsrc=%b infl=%0d err=%0b",
               cyc_n, nw, rs1, u1, rs2, u2, rd, wr, wbv, wbrd, fl,
               issue_o, stall_o, forward_src_o, inflight_o, proto_err_o);
   endtask

   task automatic idle(input logic [1:0] e_inf, input logic e_stl, input logic e_err);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_stl, 2'b00, e_inf, e_err);
   endtask

   initial begin
      // Reset state
      #12;
      check_val("rst issue", 32'(issue_o), 32'd0);
      check_val("rst stall", 32'(stall_o), 32'd0);
      check_val("rst fwd_en", 32'(forward_en_o), 32'd0);
      check_val("rst inflight", 32'(inflight_o), 32'd0);
      check_val("rst proto_err", 32'(proto_err_o), 32'd0);
      $display("reset: issue=%0b stall=%0b infl=%0d err=%0b", issue_o, stall_o, inflight_o, proto_err_o);
      @(negedge clk_i);
      rst_i = 1'b0;

      //    nw rs1 u1 rs2 u2 rd wr wbv wbrd fl | iss stl fs     inf err
      // Independent ops
      cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 0,   1, 0, 2'b00, 2'd0, 0);
      cyc(1, 6, 1, 7, 1, 0, 0, 0, 0, 0,   1, 0, 2'b00, 2'd1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 5, 0,   0, 0, 2'b00, 2'd1, 0);
      // Forward on opB
      cyc(1, 0, 0, 0, 0, 3, 1, 0, 0, 0,   1, 0, 2'b00, 2'd0, 0);
      cyc(1, 0, 0, 3, 1, 0, 0, 1, 3, 0,   1, 0, 2'b10, 2'd1, 0);
      // Stall three cycles, then forward on opA
      cyc(1, 0, 0, 0, 0, 4, 1, 0, 0, 0,   1, 0, 2'b00, 2'd0, 0);
      cyc(1, 4, 1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 2'b00, 2'd1, 0);
      idle(2'd1, 1, 0);
      idle(2'd1, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 4, 0,   1, 0, 2'b01, 2'd1, 0);
      // Full scoreboard: stall until first wb, then push+pop keeps 2
      cyc(1, 0, 0, 0, 0, 1, 1, 0, 0, 0,   1, 0, 2'b00, 2'd0, 0);
      cyc(1, 0, 0, 0, 0, 2, 1, 0, 0, 0,   1, 0, 2'b00, 2'd1, 0);
      cyc(1, 0, 0, 0, 0, 8, 1, 0, 0, 0,   0, 1, 2'b00, 2'd2, 0);
      idle(2'd2, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   1, 0, 2'b00, 2'd2, 0);
      idle(2'd2, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 2, 0,   0, 0, 2'b00, 2'd2, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 8, 0,   0, 0, 2'b00, 2'd1, 0);
      // x0 never tracked
      cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0,   1, 0, 2'b00, 2'd0, 0);
      // Flush while waiting
      cyc(1, 0, 0, 0, 0, 9, 1, 0, 0, 0,   1, 0, 2'b00, 2'd0, 0);
      cyc(1, 9, 1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 2'b00, 2'd1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 2'b00, 2'd1, 0);
      cyc(1, 9, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 2'b00, 2'd0, 0);
      // Flush drops a same-cycle new instruction
      cyc(1, 0, 0, 0, 0,10, 1, 0, 0, 1,   0, 0, 2'b00, 2'd0, 0);
      idle(2'd0, 0, 0);
      // New instruction during stall -> sticky error
      cyc(1, 0, 0, 0, 0,11, 1, 0, 0, 0,   1, 0, 2'b00, 2'd0, 0);
      cyc(1, 0, 0,11, 1, 0, 0, 0, 0, 0,   0, 1, 2'b00, 2'd1, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 2'b00, 2'd1, 0);
      idle(2'd1, 1, 1);

      // Asynchronous reset in WAIT takes effect without a clock edge
      @(negedge clk_i);
      #1 rst_i = 1'b1;
      #1;
      check_val("arst stall", 32'(stall_o), 32'd0);
      check_val("arst inflight", 32'(inflight_o), 32'd0);
      check_val("arst proto_err", 32'(proto_err_o), 32'd0);
      $display("async reset: stall=%0b infl=%0d err=%0b", stall_o, inflight_o, proto_err_o);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Writeback with empty scoreboard -> sticky error
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 0,   0, 0, 2'b00, 2'd0, 0);
      idle(2'd0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 2'b00, 2'd0, 1);
      idle(2'd0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
